// File: rtl/bsg_credit_pool_arbiter.sv
// Round-robin arbiter sharing one credit pool among els_p requesters.
// A bootstrap phase tops up the pool after reset before grants are allowed.
module bsg_credit_pool_arbiter #(
    parameter int unsigned els_p          = 4,
    parameter int unsigned max_credits_p  = 16,
    parameter int unsigned init_credits_p = 8,
    parameter int unsigned boot_credits_p = 4,
    parameter int unsigned max_return_p   = 2,
    localparam int unsigned count_width_lp = $clog2(max_credits_p + 1),
    localparam int unsigned ret_width_lp   = $clog2(max_return_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [els_p-1:0]          v_i,
    output logic [els_p-1:0]          yumi_o,
    input  logic [ret_width_lp-1:0]   credit_return_i,
    output logic [count_width_lp-1:0] credits_o,
    output logic                      boot_done_o,
    output logic                      overflow_o
);

    localparam int unsigned ptr_width_lp  = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned boot_width_lp = (boot_credits_p > 0) ? $clog2(boot_credits_p + 1) : 1;
    localparam int unsigned sum_width_lp  = count_width_lp + 2;

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    state_e                    state_q, state_d;
    logic [count_width_lp-1:0] credits_q, credits_d;
    logic [ptr_width_lp-1:0]   rr_q, rr_d;
    logic [boot_width_lp-1:0]  boot_cnt_q, boot_cnt_d;
    logic                      overflow_q, overflow_d;

    logic                      in_boot;
    logic                      in_run;
    logic                      grant_v;
    logic [ptr_width_lp-1:0]   grant_idx;
    logic [els_p-1:0]          hi_mask;
    logic [els_p-1:0]          cand;
    logic [sum_width_lp-1:0]   sum;

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= (boot_credits_p > 0) ? StBoot : StRun;
            credits_q  <= count_width_lp'(init_credits_p);
            rr_q       <= '0;
            boot_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            credits_q  <= credits_d;
            rr_q       <= rr_d;
            boot_cnt_q <= boot_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StBoot: begin
                if (boot_cnt_q == boot_width_lp'(boot_credits_p - 1)) begin
                    state_d = StRun;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = state_q;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_boot     = (state_q == StBoot);
        in_run      = (state_q == StRun);
        boot_done_o = in_run;
    end

    assign boot_cnt_d = in_boot ? boot_cnt_q + boot_width_lp'(1) : boot_cnt_q;

    // Prefer requesters at or above the pointer; fall back to the lowest index to wrap.
    always_comb begin
        hi_mask = '0;
        for (int j = 0; j < els_p; j++) begin
            hi_mask[j] = (ptr_width_lp'(j) >= rr_q);
        end
        cand = ((v_i & hi_mask) != '0) ? (v_i & hi_mask) : v_i;

        grant_v   = 1'b0;
        grant_idx = '0;
        yumi_o    = '0;
        if (reset_n_i && in_run && (credits_q != '0)) begin
            for (int j = els_p - 1; j >= 0; j--) begin
                if (cand[j]) begin
                    grant_v   = 1'b1;
                    grant_idx = ptr_width_lp'(j);
                    yumi_o    = '0;
                    yumi_o[j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (grant_v) begin
            rr_d = (grant_idx == ptr_width_lp'(els_p - 1)) ? '0 : grant_idx + ptr_width_lp'(1);
        end
    end

    // Widened sum so a full pool plus a maximal return cannot wrap before saturation.
    always_comb begin
        sum = sum_width_lp'(credits_q) + sum_width_lp'(credit_return_i)
            + sum_width_lp'(in_boot) - sum_width_lp'(grant_v);
        overflow_d = overflow_q;
        if (sum > sum_width_lp'(max_credits_p)) begin
            credits_d  = count_width_lp'(max_credits_p);
            overflow_d = 1'b1;
        end else begin
            credits_d  = sum[count_width_lp-1:0];
        end
    end

    assign credits_o  = credits_q;
    assign overflow_o = overflow_q;

`ifndef SYNTHESIS
    a_return_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        credit_return_i <= ret_width_lp'(max_return_p));
    a_yumi_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        $onehot0(yumi_o));
`endif

endmodule
